// File: rtl/gomoku_pkg.sv
// Shared Gomoku definitions: button FSM encoding and default hold/repeat timing.
package gomoku_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE   = 2'd0,
        BTN_ARMED  = 2'd1,
        BTN_REPEAT = 2'd2
    } btn_state_e;

    // 0.5 s before long-press / first repeat, 0.1 s between repeats at 100 MHz.
    localparam int unsigned BTN_LONG_CYCLES   = 50_000_000;
    localparam int unsigned BTN_REPEAT_CYCLES = 10_000_000;

endpackage

// File: rtl/button_event_gen_if.sv
// Debounced button level in, single-cycle game-input events out.
interface button_event_gen_if;

    logic btn_level;
    logic held;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic step_pulse;

    // master: debouncer / consumer side; slave: the event generator.
    modport master (
        output btn_level,
        input  held, press_pulse, release_pulse, long_pulse, repeat_pulse, step_pulse
    );

    modport slave (
        input  btn_level,
        output held, press_pulse, release_pulse, long_pulse, repeat_pulse, step_pulse
    );

endinterface

// File: rtl/button_event_gen.sv
// Turns a debounced button level into press/release/long-press/auto-repeat strobes.
// All outputs are registered; the counter never wraps.
module button_event_gen
    import gomoku_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = BTN_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_CYCLES,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input logic               clk_100mhz,
    input logic               rst_n,
    button_event_gen_if.slave bus
);

    localparam int unsigned CntMax = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);
    localparam logic [CntW-1:0] RepLast  = CntW'(REPEAT_CYCLES - 1);

    btn_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            btn_q;
    logic            rise, fall;
    logic            press_d, release_d, long_d, repeat_d, step_d;
    logic            press_q, release_q, long_q, repeat_q, step_q;

    assign rise = bus.btn_level & ~btn_q;
    assign fall = ~bus.btn_level & btn_q;

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BTN_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A fall always takes priority over a threshold match; the count is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BTN_IDLE: begin
                if (rise) begin
                    state_d = BTN_ARMED;
                    cnt_d   = '0;
                end
            end
            BTN_ARMED: begin
                if (fall) begin
                    state_d = BTN_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LongLast) begin
                    state_d = BTN_REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            BTN_REPEAT: begin
                if (fall) begin
                    state_d = BTN_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == RepLast) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = BTN_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        unique case (state_q)
            BTN_IDLE: press_d = rise;
            BTN_ARMED: begin
                release_d = fall;
                long_d    = ~fall & (cnt_q == LongLast);
                repeat_d  = long_d & REPEAT_EN;
            end
            BTN_REPEAT: begin
                release_d = fall;
                repeat_d  = ~fall & (cnt_q == RepLast) & REPEAT_EN;
            end
            default: ;
        endcase
        step_d = press_d | repeat_d;
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            btn_q     <= bus.btn_level;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            step_q    <= step_d;
        end
    end

    assign bus.held          = btn_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.step_pulse    = step_q;

endmodule
